// File: rtl/fir_io_pkg.sv
// fir_io_pkg: FIR result-framing constants, shared by the GPIO transmitter and the firmware header generator.
package fir_io_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_SEP, ST_DATA, ST_END} tx_state_e;

    localparam logic [15:0] DFLT_START_MARK = 16'hAB40;
    localparam logic [15:0] DFLT_END_MARK   = 16'hAB51;
    localparam logic [15:0] DFLT_SEP_WORD   = 16'hFFFF;
    localparam logic [15:0] SUB_WORD        = 16'hFFFE;

    // A sample equal to the separator would be ambiguous on the bus, so it is nudged down by one.
    function automatic logic [15:0] sub_sample(input logic [15:0] s);
        return (s == 16'hFFFF) ? SUB_WORD : s;
    endfunction

endpackage

// File: rtl/fir_checkbits_tx.sv
// fir_checkbits_tx: streams FIR samples onto mprj_io[31:16] as a held-word frame
// (start marker, separator/data pairs, end marker) for a polling receiver.
module fir_checkbits_tx
    import fir_io_pkg::*;
#(
    parameter int          TEST_LENGTH = 64,
    parameter int          HOLD_CYCLES = 4,
    parameter logic [15:0] START_MARK  = DFLT_START_MARK,
    parameter logic [15:0] END_MARK    = DFLT_END_MARK,
    parameter logic [15:0] SEP_WORD    = DFLT_SEP_WORD
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic        ss_tvalid,
    input  logic [31:0] ss_tdata,
    input  logic        ss_tlast,
    output logic        ss_tready,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb,
    output logic        busy,
    output logic        sat_flag,
    output logic        len_err
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int CW = $clog2(TEST_LENGTH + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LEN       = CW'(TEST_LENGTH);

    tx_state_e     state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   data_q, data_d;
    logic [15:0]   io_out_q, io_out_d;
    logic [15:0]   oeb_q, oeb_d;
    logic          sat_q, sat_d;
    logic          len_q, len_d;
    logic          hold_done, accept, last_sample;
    logic          unused_hi;

    assign unused_hi   = ^ss_tdata[31:16];
    assign hold_done   = hold_q == HOLD_LAST;
    assign ss_tready   = (state_q == ST_SEP) && hold_done;
    assign accept      = ss_tready && ss_tvalid;
    assign last_sample = (cnt_q + 1'b1) == LEN;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_done ? hold_q : hold_q + 1'b1;
        cnt_d   = cnt_q;
        data_d  = data_q;
        oeb_d   = oeb_q;
        sat_d   = sat_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_START;
                    oeb_d   = '0;
                end
            end
            ST_START: state_d = hold_done ? ST_SEP : ST_START;
            ST_SEP: begin
                if (accept) begin
                    state_d = ST_DATA;
                    cnt_d   = cnt_q + 1'b1;
                    data_d  = sub_sample(ss_tdata[15:0]);
                    sat_d   = sat_q | (ss_tdata[15:0] == 16'hFFFF);
                    // Early tlast and missing tlast on the final sample are both length errors.
                    len_d   = len_q | (ss_tlast != last_sample);
                end
            end
            ST_DATA: begin
                if (hold_done) state_d = (cnt_q == LEN || len_q) ? ST_END : ST_SEP;
            end
            ST_END: state_d = start ? ST_START : ST_END;
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) hold_d = '0;
        if (state_d == ST_START && state_q != ST_START) begin
            cnt_d = '0;
            sat_d = 1'b0;
            len_d = 1'b0;
        end
        io_out_d = (state_q == ST_START) ? START_MARK :
                   (state_q == ST_SEP)   ? SEP_WORD   :
                   (state_q == ST_DATA)  ? data_q     :
                   (state_q == ST_END)   ? END_MARK   : 16'h0000;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            io_out_q <= '0;
            oeb_q    <= 16'hFFFF;
            sat_q    <= 1'b0;
            len_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            io_out_q <= io_out_d;
            oeb_q    <= oeb_d;
            sat_q    <= sat_d;
            len_q    <= len_d;
        end
    end

    assign io_out   = io_out_q;
    assign io_oeb   = oeb_q;
    assign busy     = !(state_q == ST_IDLE || state_q == ST_END);
    assign sat_flag = sat_q;
    assign len_err  = len_q;

endmodule
